// File: rtl/hop_ctrl.sv
// hop_ctrl: native clock counter and hop-engine sequencer with channel handshake
module hop_ctrl #(
    parameter int TRAIN_TICKS = 8192,
    parameter int KOFF_A = 24,
    parameter int KOFF_B = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        clk_load,
    input  logic [27:0] clk_init,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [6:0]  hop_in,
    input  logic        chan_ack,
    output logic [4:0]  x,
    output logic        y1,
    output logic [4:0]  y2,
    output logic [27:0] clk_cnt,
    output logic [6:0]  chan,
    output logic        chan_valid,
    output logic        overrun,
    output logic        busy,
    output logic        train
);
    localparam logic [12:0] TLAST = 13'(TRAIN_TICKS - 1);
    localparam logic [4:0] KA = 5'(KOFF_A);
    localparam logic [4:0] KB = 5'(KOFF_B);

    typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        pending, pend_nxt;
    logic        page_q, page_e;
    logic        go, qual, load_x, capture;
    logic [27:0] clk_nxt;
    logic [12:0] tcnt, tcnt_nxt;
    logic        train_nxt;
    logic [4:0]  koff, x_nxt;
    logic [3:0]  diff;

    assign busy    = state != IDLE;
    assign go      = state == IDLE && start && !stop;
    assign clk_nxt = (state == IDLE && clk_load) ? clk_init : clk_cnt + 28'(tick);
    assign page_e  = go ? (mode == 2'b01 || mode == 2'b10) : page_q;
    assign qual    = busy && tick && (page_q || clk_cnt[0]);
    assign capture = state == LOAD && !stop;

    // x/y are computed from the clock value that becomes current on this edge,
    // so a tick and the LOAD it triggers land in the same cycle
    assign koff  = train_nxt ? KB : KA;
    assign diff  = {clk_nxt[4:2], clk_nxt[0]} - clk_nxt[15:12];
    assign x_nxt = page_e ? clk_nxt[16:12] + koff + {1'b0, diff} : clk_nxt[6:2];

    // train counter: ticks while busy in page/inquiry, toggling train at wrap
    always_comb begin
        tcnt_nxt  = tcnt;
        train_nxt = train;
        if (go) begin
            tcnt_nxt  = '0;
            train_nxt = 1'b0;
        end else if (busy && page_q && tick) begin
            tcnt_nxt  = (tcnt == TLAST) ? '0 : tcnt + 13'd1;
            train_nxt = (tcnt == TLAST) ? ~train : train;
        end
    end

    // next state, pending flag and x/y load strobe
    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        load_x    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = go ? LOAD : IDLE;
                load_x    = go;
            end
            LOAD: begin
                state_nxt = CAPTURE;
                pend_nxt  = pending | qual;
            end
            CAPTURE: begin
                state_nxt = (pending || qual) ? LOAD : WAIT;
                load_x    = pending || qual;
                pend_nxt  = 1'b0;
            end
            WAIT: begin
                state_nxt = qual ? LOAD : WAIT;
                load_x    = qual;
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            pend_nxt  = 1'b0;
            load_x    = 1'b0;
        end
    end

    // native clock: load only in IDLE, otherwise count ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_cnt <= '0;
        else        clk_cnt <= clk_nxt;
    end

    // state register and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pend_nxt;
        end
    end

    // sequence type latched at start, train counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q <= 1'b0;
            tcnt   <= '0;
            train  <= 1'b0;
        end else begin
            page_q <= page_e;
            tcnt   <= tcnt_nxt;
            train  <= train_nxt;
        end
    end

    // hop engine inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            y1 <= 1'b0;
            y2 <= '0;
        end else if (load_x) begin
            x  <= x_nxt;
            y1 <= clk_nxt[1];
            y2 <= {clk_nxt[1], 4'b0};
        end
    end

    // channel latch, consumer handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan       <= '0;
            chan_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (capture) begin
                chan       <= hop_in;
                chan_valid <= 1'b1;
                overrun    <= overrun | (chan_valid & ~chan_ack);
            end else if (chan_ack) begin
                chan_valid <= 1'b0;
            end
            if (go) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hop_ctrl.sv
// tb_hop_ctrl: directed vectors plus randomized run against a behavioural model
module tb_hop_ctrl;
    localparam int TT = 4;

    logic        clk = 0, rst_n = 0;
    logic        tick = 0, clk_load = 0, start = 0, stop = 0, chan_ack = 0;
    logic [27:0] clk_init = 0;
    logic [1:0]  mode = 0;
    logic [6:0]  hop_in = 0;
    logic [4:0]  x, y2;
    logic        y1, chan_valid, overrun, busy, train;
    logic [27:0] clk_cnt;
    logic [6:0]  chan;
    logic [49:0] dv;

    int checks = 0, errors = 0;

    hop_ctrl #(.TRAIN_TICKS(TT), .KOFF_A(24), .KOFF_B(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clk_load(clk_load), .clk_init(clk_init),
        .start(start), .stop(stop), .mode(mode), .hop_in(hop_in), .chan_ack(chan_ack),
        .x(x), .y1(y1), .y2(y2), .clk_cnt(clk_cnt), .chan(chan), .chan_valid(chan_valid),
        .overrun(overrun), .busy(busy), .train(train)
    );

    always #5 clk = ~clk;

    assign dv = {clk_cnt, x, y1, y2, chan, chan_valid, overrun, busy, train};

    // model: phase 0 idle, 1 hop inputs presented, 2 channel just latched, 3 waiting for tick
    logic [27:0] m_clk;
    logic [4:0]  m_x;
    logic [6:0]  m_chan;
    logic        m_y1, m_cv, m_ov, m_busy, m_train, m_page, m_pend;
    int          m_tcnt, m_phase;

    function automatic logic [49:0] mvec();
        return {m_clk, m_x, m_y1, {m_y1, 4'b0}, m_chan, m_cv, m_ov, m_busy, m_train};
    endfunction

    function automatic logic [4:0] hop_x(logic [27:0] c);
        int k, d;
        if (!m_page) return c[6:2];
        k = m_train ? 8 : 24;
        d = ((int'(c[4:2]) * 2 + int'(c[0])) - int'(c[15:12]) + 16) % 16;
        return 5'((int'(c[16:12]) + k + d) % 32);
    endfunction

    task automatic model_reset();
        m_clk = 0; m_x = 0; m_chan = 0; m_y1 = 0; m_cv = 0; m_ov = 0;
        m_busy = 0; m_train = 0; m_page = 0; m_pend = 0; m_tcnt = 0; m_phase = 0;
    endtask

    task automatic model_step();
        logic [27:0] nclk;
        bit go, qual, cap, reload;
        nclk = (!m_busy && clk_load) ? clk_init : m_clk + 28'(tick);
        go = !m_busy && start && !stop;
        qual = m_busy && tick && (m_page || !nclk[0]);
        cap = m_phase == 1 && !stop;
        if (go) begin
            m_tcnt = 0; m_train = 0; m_page = (mode == 1 || mode == 2);
        end else if (m_busy && m_page && tick) begin
            m_tcnt++;
            if (m_tcnt == TT) begin m_tcnt = 0; m_train = !m_train; end
        end
        if (cap) begin
            if (m_cv && !chan_ack) m_ov = 1;
            m_chan = hop_in; m_cv = 1;
        end else if (chan_ack) m_cv = 0;
        if (go) m_ov = 0;
        reload = go || (m_phase == 2 && (m_pend || qual)) || (m_phase == 3 && qual);
        if (m_phase == 1 && qual) m_pend = 1;
        if (stop) begin
            m_phase = 0; m_busy = 0; m_pend = 0;
        end else if (reload) begin
            m_phase = 1; m_busy = 1; m_pend = 0; m_x = hop_x(nclk); m_y1 = nclk[1];
        end else if (m_phase == 1 || m_phase == 2) m_phase++;
        m_clk = nclk;
    endtask

    task automatic check(string name, logic [49:0] got, logic [49:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        tick = 0; clk_load = 0; clk_init = 0; start = 0; stop = 0; mode = 0; hop_in = 0; chan_ack = 0;
    endtask

    task automatic do_reset(string name);
        clear_inputs();
        rst_n = 0;
        #1;
        model_reset();
        check(name, dv, 50'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic tk, ld; logic [27:0] ini; logic st, sp; logic [1:0] md; logic [6:0] hop; logic ack;
        logic [27:0] e_clk; logic [4:0] e_x; logic e_y1; logic [6:0] e_ch; logic e_cv, e_ov, e_b, e_t;
    } vec_t;

    vec_t tbl[37];

    initial begin
        tbl[0]  = '{0,1,28'h4C,0,0,0,0,0,        28'h4C,0,0,0,0,0,0,0};
        tbl[1]  = '{0,0,0,1,0,0,0,0,             28'h4C,19,0,0,0,0,1,0};
        tbl[2]  = '{0,0,0,0,0,0,33,0,            28'h4C,19,0,33,1,0,1,0};
        tbl[3]  = '{0,0,0,0,0,0,0,0,             28'h4C,19,0,33,1,0,1,0};
        tbl[4]  = '{1,0,0,0,0,0,0,0,             28'h4D,19,0,33,1,0,1,0};
        tbl[5]  = '{0,0,0,0,0,0,0,0,             28'h4D,19,0,33,1,0,1,0};
        tbl[6]  = '{1,0,0,0,0,0,0,0,             28'h4E,19,1,33,1,0,1,0};
        tbl[7]  = '{0,0,0,0,0,0,44,0,            28'h4E,19,1,44,1,1,1,0};
        tbl[8]  = '{0,0,0,0,0,0,0,1,             28'h4E,19,1,44,0,1,1,0};
        tbl[9]  = '{0,0,0,0,1,0,0,0,             28'h4E,19,1,44,0,1,0,0};
        tbl[10] = '{0,1,0,0,0,0,0,0,             0,19,1,44,0,1,0,0};
        tbl[11] = '{0,0,0,1,0,1,0,0,             0,24,0,44,0,0,1,0};
        tbl[12] = '{0,0,0,0,0,0,5,1,             0,24,0,5,1,0,1,0};
        tbl[13] = '{0,0,0,0,0,0,0,0,             0,24,0,5,1,0,1,0};
        tbl[14] = '{1,0,0,0,0,0,0,0,             1,25,0,5,1,0,1,0};
        tbl[15] = '{0,0,0,0,0,0,6,1,             1,25,0,6,1,0,1,0};
        tbl[16] = '{1,0,0,0,0,0,0,0,             2,24,1,6,1,0,1,0};
        tbl[17] = '{1,0,0,0,0,0,7,0,             3,24,1,7,1,1,1,0};
        tbl[18] = '{1,0,0,0,0,0,0,0,             4,10,0,7,1,1,1,1};
        tbl[19] = '{0,0,0,0,0,0,8,0,             4,10,0,8,1,1,1,1};
        tbl[20] = '{0,0,0,0,0,0,0,1,             4,10,0,8,0,1,1,1};
        tbl[21] = '{1,0,0,0,0,0,0,0,             5,11,0,8,0,1,1,1};
        tbl[22] = '{0,0,0,0,0,0,9,0,             5,11,0,9,1,1,1,1};
        tbl[23] = '{0,0,0,0,0,0,0,0,             5,11,0,9,1,1,1,1};
        tbl[24] = '{1,0,0,0,0,0,0,0,             6,10,1,9,1,1,1,1};
        tbl[25] = '{0,0,0,0,0,0,10,1,            6,10,1,10,1,1,1,1};
        tbl[26] = '{0,0,0,0,0,0,0,0,             6,10,1,10,1,1,1,1};
        tbl[27] = '{1,0,0,0,0,0,0,0,             7,11,1,10,1,1,1,1};
        tbl[28] = '{0,0,0,0,0,0,11,0,            7,11,1,11,1,1,1,1};
        tbl[29] = '{0,1,28'h123,0,0,0,0,0,       7,11,1,11,1,1,1,1};
        tbl[30] = '{1,0,0,0,0,0,0,0,             8,28,0,11,1,1,1,0};
        tbl[31] = '{0,0,0,0,1,0,0,0,             8,28,0,11,1,1,0,0};
        tbl[32] = '{1,1,28'h55,0,0,0,0,0,        28'h55,28,0,11,1,1,0,0};
        tbl[33] = '{1,0,0,0,0,0,0,0,             28'h56,28,0,11,1,1,0,0};
        tbl[34] = '{0,0,0,1,1,0,0,0,             28'h56,28,0,11,1,1,0,0};
        tbl[35] = '{0,1,28'hFFFFFFF,0,0,0,0,0,   28'hFFFFFFF,28,0,11,1,1,0,0};
        tbl[36] = '{1,0,0,0,0,0,0,0,             0,28,0,11,1,1,0,0};

        repeat (2) @(negedge clk);
        do_reset("reset state");

        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            tick = tbl[i].tk; clk_load = tbl[i].ld; clk_init = tbl[i].ini; start = tbl[i].st;
            stop = tbl[i].sp; mode = tbl[i].md; hop_in = tbl[i].hop; chan_ack = tbl[i].ack;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dv,
                  {tbl[i].e_clk, tbl[i].e_x, tbl[i].e_y1, {tbl[i].e_y1, 4'b0}, tbl[i].e_ch,
                   tbl[i].e_cv, tbl[i].e_ov, tbl[i].e_b, tbl[i].e_t});
        end

        // reset asserted while a freshly captured channel is held
        do_reset("reset idle");
        @(negedge clk);
        start = 1; mode = 0;
        model_step();
        @(posedge clk); #1;
        check("rseq start", dv, mvec());
        @(negedge clk);
        start = 0; hop_in = 50;
        model_step();
        @(posedge clk); #1;
        check("rseq capture", dv, {28'd0, 5'd0, 1'b0, 5'd0, 7'd50, 1'b1, 1'b0, 1'b1, 1'b0});
        #1;
        do_reset("reset in capture");
        @(negedge clk);
        tick = 1;
        model_step();
        @(posedge clk); #1;
        check("tick only", dv, {28'd1, 22'd0});

        do_reset("reset before random");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tick = $urandom_range(0, 99) < 30;
            clk_load = $urandom_range(0, 99) < 4;
            clk_init = ($urandom_range(0, 3) == 0) ? 28'hFFFFFF0 + 28'($urandom_range(0, 15)) : 28'($urandom);
            start = $urandom_range(0, 99) < 5;
            stop = $urandom_range(0, 99) < 2;
            mode = 2'($urandom_range(0, 3));
            hop_in = 7'($urandom_range(0, 78));
            chan_ack = $urandom_range(0, 99) < 40;
            model_step();
            @(posedge clk); #1;
            check("random", dv, mvec());
            if (i == 1500) begin
                #1;
                do_reset("random reset");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
